// File: rtl/mac_result_streamer_if.sv
// AXI4-Stream channel carrying signed result elements out of the MAC read-out path.
interface mac_result_streamer_if #(
  parameter int OUT_W = 16
);
  logic signed [OUT_W-1:0] tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/mac_result_streamer.sv
// Snapshots the NxN MAC accumulator matrix and streams it row-major as AXI4-Stream, TLAST on the last element.
// Optional feature macro: RESULT_SAT_EN (signed saturation of each element to OUT_W; default is two's-complement wrap).
module mac_result_streamer #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] acc [N][N],
  output logic                    snap,
  output logic                    busy,
  output logic                    done,
  mac_result_streamer_if.master   m_axis
);

  localparam int NUM_EL = N * N;
  localparam int IDX_W  = $clog2(NUM_EL);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EL - 1);

`ifdef RESULT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] conv(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      conv = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) conv = SAT_MIN[OUT_W-1:0];
    else                  conv = v[OUT_W-1:0];
  endfunction
`else
  function automatic logic signed [OUT_W-1:0] conv(input logic signed [ACC_W-1:0] v);
    conv = v[OUT_W-1:0];
  endfunction
`endif

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [IDX_W-1:0]        idx_inc;
  logic signed [OUT_W-1:0] tdata_reg;
  logic                    tvalid_reg;
  logic                    tlast_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    snap_reg;
  logic signed [OUT_W-1:0] acc_conv     [NUM_EL];
  logic signed [OUT_W-1:0] snap_buf_reg [NUM_EL];

  // Conversion happens before capture so the buffer only holds OUT_W-wide elements.
  for (genvar gi = 0; gi < NUM_EL; gi++) begin : g_conv
    assign acc_conv[gi] = conv(acc[gi / N][gi % N]);
  end

  assign idx_inc = idx_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      tdata_reg  <= '0;
      tvalid_reg <= 1'b0;
      tlast_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      snap_reg   <= 1'b0;
      for (int k = 0; k < NUM_EL; k++) snap_buf_reg[k] <= '0;
    end else begin
      snap_reg <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_EL; k++) snap_buf_reg[k] <= acc_conv[k];
            tdata_reg  <= acc_conv[0];
            tvalid_reg <= 1'b1;
            tlast_reg  <= 1'b0;
            idx_reg    <= '0;
            busy_reg   <= 1'b1;
            snap_reg   <= 1'b1;
            state_reg  <= STREAM;
          end
        end
        STREAM: begin
          // Outputs only move on a handshake, which keeps them stable through stalls.
          if (tvalid_reg && m_axis.tready) begin
            if (idx_reg == LAST_IDX) begin
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              idx_reg   <= idx_inc;
              tdata_reg <= snap_buf_reg[idx_inc];
              tlast_reg <= (idx_inc == LAST_IDX);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tlast  = tlast_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign snap          = snap_reg;

endmodule

// File: tb/tb_mac_result_streamer.sv
// Directed bench for mac_result_streamer: bursts, stalls, snapshot isolation, conversion, reset and back-to-back frames.
module tb_mac_result_streamer;

  logic clk;
  logic rst_n;
  logic start;
  logic snap;
  logic busy;
  logic done;
  logic signed [31:0] acc [4][4];

  mac_result_streamer_if #(.OUT_W(16)) axis ();

  mac_result_streamer #(.N(4), .ACC_W(32), .OUT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .acc    (acc),
    .snap   (snap),
    .busy   (busy),
    .done   (done),
    .m_axis (axis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  int beat_val  [32];
  bit beat_last [32];
  int nbeats;
  int done_cyc;
  int hold_err;
  int snap_cnt;
  int busy_low;

  task automatic set_acc(input int base, input bit ramp);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        acc[i][j] = ramp ? (i * 4 + j + base) : 0;
  endtask

  // Request a snapshot; returns at the first negedge after the capturing edge.
  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes the stream at negedges, recording accepted beats, until done is seen or the budget expires.
  task automatic run_frame(input bit toggle, input int inject, input int limit);
    bit                 prev_stall;
    logic signed [15:0] prev_data;
    logic               prev_last;
    bit                 rdy;
    nbeats     = 0;
    done_cyc   = -1;
    hold_err   = 0;
    snap_cnt   = 0;
    busy_low   = 0;
    prev_stall = 0;
    prev_data  = '0;
    prev_last  = 1'b0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (prev_stall && (axis.tvalid !== 1'b1 || axis.tdata !== prev_data || axis.tlast !== prev_last))
        hold_err++;
      if (snap) snap_cnt++;
      if (!busy) busy_low++;
      if (cyc == inject) begin
        acc[0][1] = 99;
        start     = 1'b1;
      end else if (cyc == inject + 1) begin
        start = 1'b0;
      end
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      axis.tready = rdy;
      if (axis.tvalid && rdy) begin
        if (nbeats < 32) begin
          beat_val[nbeats]  = int'(axis.tdata);
          beat_last[nbeats] = axis.tlast;
        end
        nbeats++;
      end
      prev_stall = axis.tvalid && !rdy;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    total++; if (axis.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", axis.tvalid); end
    total++; if (axis.tdata !== 16'sd0) begin bad++; $display("FAIL reset_tdata got=%0d want=0", axis.tdata); end
    total++; if (axis.tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b want=0", axis.tlast); end
    total++; if ({busy, done, snap} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, snap}); end
    $display("test_reset: checked idle outputs under reset");
  endtask

  task automatic test_single_burst();
    int errs;
    set_acc(0, 0);
    acc[0][0] = 12;
    start_frame();
    total++; if (snap !== 1'b1 || axis.tvalid !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL burst_start got snap=%b tvalid=%b busy=%b want 111", snap, axis.tvalid, busy);
    end
    run_frame(1'b0, -10, 64);
    total++; if (nbeats !== 16) begin bad++; $display("FAIL burst_count got=%0d want=16", nbeats); end
    total++; if (done_cyc !== 16) begin bad++; $display("FAIL burst_done_cycle got=%0d want=16", done_cyc); end
    errs = 0;
    for (int k = 0; k < 16; k++)
      if (beat_val[k] !== ((k == 0) ? 12 : 0) || beat_last[k] !== (k == 15)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL burst_beats got=%0d bad beats want=0 (beat0=%0d)", errs, beat_val[0]); end
    @(negedge clk);
    total++; if (done !== 1'b0 || axis.tvalid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL burst_after got done=%b tvalid=%b busy=%b want 000", done, axis.tvalid, busy);
    end
    $display("test_single_burst: beats=%0d done_cyc=%0d beat0=%0d", nbeats, done_cyc, beat_val[0]);
  endtask

  task automatic test_stall_toggle();
    int errs;
    set_acc(-8, 1);
    start_frame();
    run_frame(1'b1, -10, 80);
    total++; if (nbeats !== 16) begin bad++; $display("FAIL stall_count got=%0d want=16", nbeats); end
    total++; if (done_cyc !== 31) begin bad++; $display("FAIL stall_done_cycle got=%0d want=31", done_cyc); end
    total++; if (hold_err !== 0) begin bad++; $display("FAIL stall_hold got=%0d violations want=0", hold_err); end
    errs = 0;
    for (int k = 0; k < 16; k++)
      if (beat_val[k] !== k - 8 || beat_last[k] !== (k == 15)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL stall_order got=%0d bad beats want=0", errs); end
    $display("test_stall_toggle: beats=%0d first=%0d last=%0d", nbeats, beat_val[0], beat_val[15]);
  endtask

  task automatic test_snapshot_isolation();
    int errs;
    set_acc(1, 1);
    start_frame();
    run_frame(1'b0, 3, 64);
    total++; if (nbeats !== 16) begin bad++; $display("FAIL iso_count got=%0d want=16", nbeats); end
    total++; if (beat_val[1] !== 2) begin bad++; $display("FAIL iso_elem01 got=%0d want=2", beat_val[1]); end
    total++; if (snap_cnt !== 1) begin bad++; $display("FAIL iso_snap got=%0d pulses want=1", snap_cnt); end
    total++; if (busy_low !== 0) begin bad++; $display("FAIL iso_busy got=%0d low cycles want=0", busy_low); end
    errs = 0;
    for (int k = 0; k < 16; k++) if (beat_val[k] !== k + 1) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL iso_values got=%0d bad beats want=0", errs); end
    $display("test_snapshot_isolation: beats=%0d snaps=%0d elem01=%0d", nbeats, snap_cnt, beat_val[1]);
  endtask

  task automatic test_conversion();
    int exp_pos;
    int exp_neg;
`ifdef RESULT_SAT_EN
    exp_pos = 32767;
    exp_neg = -32768;
`else
    exp_pos = -25536;
    exp_neg = 25536;
`endif
    set_acc(0, 0);
    acc[0][3] = -5;
    acc[1][1] = 40000;
    acc[2][2] = -40000;
    start_frame();
    run_frame(1'b0, -10, 64);
    total++; if (beat_val[5] !== exp_pos) begin bad++; $display("FAIL conv_pos got=%0d want=%0d", beat_val[5], exp_pos); end
    total++; if (beat_val[10] !== exp_neg) begin bad++; $display("FAIL conv_neg got=%0d want=%0d", beat_val[10], exp_neg); end
    total++; if (beat_val[3] !== -5) begin bad++; $display("FAIL conv_inrange got=%0d want=-5", beat_val[3]); end
    $display("test_conversion: [1][1]->%0d [2][2]->%0d [0][3]->%0d", beat_val[5], beat_val[10], beat_val[3]);
  endtask

  task automatic test_reset_mid_stream();
    int errs;
    set_acc(100, 1);
    start_frame();
    axis.tready = 1'b1;
    repeat (5) @(negedge clk);
    axis.tready = 1'b0;
    total++; if (axis.tdata !== 16'sd105 || axis.tvalid !== 1'b1) begin
      bad++; $display("FAIL midrst_beat5 got=%0d valid=%b want=105 valid=1", axis.tdata, axis.tvalid);
    end
    rst_n = 1'b0;
    #1;
    total++; if (axis.tvalid !== 1'b0 || busy !== 1'b0 || axis.tlast !== 1'b0) begin
      bad++; $display("FAIL midrst_drop got tvalid=%b busy=%b tlast=%b want 000", axis.tvalid, busy, axis.tlast);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    run_frame(1'b0, -10, 64);
    errs = 0;
    for (int k = 0; k < 16; k++) if (beat_val[k] !== k + 100) errs++;
    total++; if (nbeats !== 16 || errs !== 0) begin
      bad++; $display("FAIL midrst_restart got beats=%0d bad=%0d want beats=16 bad=0", nbeats, errs);
    end
    $display("test_reset_mid_stream: restart beats=%0d first=%0d", nbeats, beat_val[0]);
  endtask

  task automatic test_back_to_back();
    int errs;
    set_acc(20, 1);
    start_frame();
    run_frame(1'b0, -10, 64);
    total++; if (done_cyc !== 16) begin bad++; $display("FAIL b2b_first_done got=%0d want=16", done_cyc); end
    set_acc(-30, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (snap !== 1'b1 || axis.tvalid !== 1'b1 || axis.tdata !== -16'sd30) begin
      bad++; $display("FAIL b2b_restart got snap=%b tvalid=%b tdata=%0d want 1 1 -30", snap, axis.tvalid, axis.tdata);
    end
    run_frame(1'b0, -10, 64);
    errs = 0;
    for (int k = 0; k < 16; k++) if (beat_val[k] !== k - 30 || beat_last[k] !== (k == 15)) errs++;
    total++; if (nbeats !== 16 || errs !== 0 || done_cyc !== 16) begin
      bad++; $display("FAIL b2b_second got beats=%0d bad=%0d done_cyc=%0d want 16 0 16", nbeats, errs, done_cyc);
    end
    $display("test_back_to_back: second frame beats=%0d first=%0d", nbeats, beat_val[0]);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    axis.tready = 1'b0;
    set_acc(0, 0);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_burst();
    test_stall_toggle();
    test_snapshot_isolation();
    test_conversion();
    test_reset_mid_stream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
